// File: rtl/bitplane_reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bitplane_reg_fifo
//  Brief    : DEPTH-entry bit-plane register FIFO, chunk-wise fill from the
//             feature-read path, one plane per handshake to the OPU with a
//             programmable cyclic chunk rotation. Optional column tap is
//             enabled by defining BPFIFO_ROW_TAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bitplane_reg_fifo #(
  parameter int DW    = 128,
  parameter int NCH   = 9,
  parameter int NBIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic                            SYS_CLK,
  input  logic                            SYS_RST,
  input  logic [DW-1:0]                   WR_DATA,
  input  logic                            WR_VLD,
  output logic                            WR_RDY,
  input  logic [$clog2(NBIT)-1:0]         WR_BIT,
  input  logic [$clog2(NCH)-1:0]          WR_CHUNK,
  input  logic                            WR_CLR,
  input  logic [$clog2(NBIT*NCH+1)-1:0]   NUM_BEAT,
  input  logic [3:0]                      PAT_LEN,
  input  logic [$clog2(NCH)-1:0]          ROT_STEP,
  output logic [NCH*DW-1:0]               OUT_DATA,
  output logic                            OUT_VLD,
  input  logic                            OUT_RDY,
  output logic [$clog2(NBIT)-1:0]         OUT_BIT,
  output logic                            OUT_LAST,
  output logic                            COMMIT,
  output logic [$clog2(DEPTH):0]          LEVEL
`ifdef BPFIFO_ROW_TAP_EN
  ,
  input  logic [$clog2(NCH*DW)-1:0]       ROW_TAP_SEL,
  output logic [NBIT-1:0]                 ROW_TAP
`endif
);

  localparam int c_BW  = $clog2(NBIT);
  localparam int c_CW  = $clog2(NCH);
  localparam int c_NW  = $clog2(NBIT*NCH+1);
  localparam int c_IW  = $clog2(DEPTH);
  localparam int c_PRW = 4 + c_CW;
  localparam int c_OW  = NCH*DW;

  logic [c_OW-1:0]  r_mem [DEPTH][NBIT];
  logic [c_IW:0]    r_wptr;
  logic [c_IW:0]    r_rptr;
  logic [c_NW-1:0]  r_bcnt;
  logic [c_BW-1:0]  r_rb;
  logic [3:0]       r_pc;
  logic             r_commit;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_last_beat;
  logic             w_hs;
  logic             w_pop;
  logic [3:0]       w_pat_max;
  logic [c_IW-1:0]  w_widx;
  logic [c_IW-1:0]  w_ridx;
  logic [c_PRW-1:0] w_prod;
  logic [c_PRW-1:0] w_rotw;
  logic [c_OW-1:0]  w_plane;
  logic [c_OW-1:0]  w_out;

  assign w_widx      = r_wptr[c_IW-1:0];
  assign w_ridx      = r_rptr[c_IW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_IW] != r_rptr[c_IW]) && (w_widx == w_ridx);
  assign w_wr        = WR_VLD && !w_full;
  assign w_last_beat = w_wr && (r_bcnt == NUM_BEAT - c_NW'(1));
  assign w_hs        = !w_empty && OUT_RDY;
  assign w_pop       = w_hs && (r_rb == c_BW'(NBIT-1));
  assign w_pat_max   = (PAT_LEN == 4'd0) ? 4'd0 : PAT_LEN - 4'd1;

  // Product kept at full width so the modulo sees the true pc*ROT_STEP value
  assign w_prod  = {{c_CW{1'b0}}, r_pc} * {4'b0000, ROT_STEP};
  assign w_rotw  = w_prod % c_PRW'(NCH);
  assign w_plane = r_mem[w_ridx][r_rb];

  // Chunk 0 sits in the MSBs; output chunk k takes stored chunk (k+rot) mod NCH
  always_comb begin
    int v_src;
    w_out = '0;
    for (int k = 0; k < NCH; k++) begin
      v_src = k + int'(w_rotw);
      if (v_src >= NCH) v_src = v_src - NCH;
      w_out[(NCH-1-k)*DW +: DW] = w_plane[(NCH-1-v_src)*DW +: DW];
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      for (int e = 0; e < DEPTH; e++)
        for (int b = 0; b < NBIT; b++)
          r_mem[e][b] <= '0;
    end else if (w_wr) begin
      // Out-of-range chunk indices match no k and so write nothing
      for (int k = 0; k < NCH; k++)
        if (WR_CHUNK == c_CW'(k))
          r_mem[w_widx][WR_BIT][(NCH-1-k)*DW +: DW] <= WR_CLR ? '0 : WR_DATA;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_bcnt   <= '0;
      r_rb     <= '0;
      r_pc     <= '0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_last_beat;
      if (w_wr) begin
        if (w_last_beat) begin
          r_bcnt <= '0;
          r_wptr <= r_wptr + 1'b1;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
      if (w_hs) begin
        if (w_pop) begin
          r_rb   <= '0;
          r_rptr <= r_rptr + 1'b1;
          r_pc   <= (r_pc >= w_pat_max) ? 4'd0 : r_pc + 4'd1;
        end else begin
          r_rb <= r_rb + 1'b1;
        end
      end
    end
  end

  assign WR_RDY   = !w_full;
  assign OUT_VLD  = !w_empty;
  assign OUT_DATA = w_out;
  assign OUT_BIT  = r_rb;
  assign OUT_LAST = !w_empty && (r_rb == c_BW'(NBIT-1));
  assign COMMIT   = r_commit;
  assign LEVEL    = r_wptr - r_rptr;

`ifdef BPFIFO_ROW_TAP_EN
  localparam int c_TW = $clog2(NCH*DW);

  always_comb begin
    ROW_TAP = '0;
    if (!w_empty && ({1'b0, ROW_TAP_SEL} < (c_TW+1)'(c_OW)))
      for (int b = 0; b < NBIT; b++)
        ROW_TAP[b] = r_mem[w_ridx][b][ROW_TAP_SEL];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitplane_reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitplane_reg_fifo
//  Brief    : Scoreboard bench for bitplane_reg_fifo (DW=8, NCH=3, NBIT=2,
//             DEPTH=4); column-tap checks compile in with BPFIFO_ROW_TAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitplane_reg_fifo;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST = 1'b0;
  logic [7:0]  WR_DATA = '0;
  logic        WR_VLD  = 1'b0;
  logic        WR_RDY;
  logic [0:0]  WR_BIT  = '0;
  logic [1:0]  WR_CHUNK = '0;
  logic        WR_CLR  = 1'b0;
  logic [2:0]  NUM_BEAT = 3'd6;
  logic [3:0]  PAT_LEN = 4'd1;
  logic [1:0]  ROT_STEP = 2'd0;
  logic [23:0] OUT_DATA;
  logic        OUT_VLD;
  logic        OUT_RDY = 1'b0;
  logic [0:0]  OUT_BIT;
  logic        OUT_LAST;
  logic        COMMIT;
  logic [2:0]  LEVEL;
`ifdef BPFIFO_ROW_TAP_EN
  logic [4:0]  ROW_TAP_SEL = '0;
  logic [1:0]  ROW_TAP;
`endif

  bitplane_reg_fifo #(.DW(8), .NCH(3), .NBIT(2), .DEPTH(4)) u_dut (
    .SYS_CLK (SYS_CLK),
    .SYS_RST (SYS_RST),
    .WR_DATA (WR_DATA),
    .WR_VLD  (WR_VLD),
    .WR_RDY  (WR_RDY),
    .WR_BIT  (WR_BIT),
    .WR_CHUNK(WR_CHUNK),
    .WR_CLR  (WR_CLR),
    .NUM_BEAT(NUM_BEAT),
    .PAT_LEN (PAT_LEN),
    .ROT_STEP(ROT_STEP),
    .OUT_DATA(OUT_DATA),
    .OUT_VLD (OUT_VLD),
    .OUT_RDY (OUT_RDY),
    .OUT_BIT (OUT_BIT),
    .OUT_LAST(OUT_LAST),
    .COMMIT  (COMMIT),
    .LEVEL   (LEVEL)
`ifdef BPFIFO_ROW_TAP_EN
    ,
    .ROW_TAP_SEL(ROW_TAP_SEL),
    .ROW_TAP    (ROW_TAP)
`endif
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct packed {
    logic [23:0] d;
    logic        b;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t r_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge
  always @(negedge SYS_CLK) begin
    if (SYS_RST && OUT_VLD && OUT_RDY) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_plane: got %0h expected no plane", OUT_DATA);
      end else begin
        r_exp = sb.pop_front();
        chk("out_data", 32'(OUT_DATA), 32'(r_exp.d));
        chk("out_bit",  32'(OUT_BIT),  32'(r_exp.b));
        chk("out_last", 32'(OUT_LAST), 32'(r_exp.last));
      end
    end
  end

  task automatic expect_entry(input logic [23:0] p0, input logic [23:0] p1);
    sb.push_back('{d: p0, b: 1'b0, last: 1'b0});
    sb.push_back('{d: p1, b: 1'b1, last: 1'b1});
  endtask

  task automatic wr_beat(input logic b, input logic [1:0] ch, input logic [7:0] d, input logic clr);
    WR_VLD   = 1'b1;
    WR_BIT   = b;
    WR_CHUNK = ch;
    WR_DATA  = d;
    WR_CLR   = clr;
    @(posedge SYS_CLK);
    #1;
    WR_VLD = 1'b0;
    WR_CLR = 1'b0;
  endtask

  task automatic wr_entry(input logic [23:0] p0, input logic [23:0] p1);
    logic [23:0] p;
    for (int b = 0; b < 2; b++) begin
      p = (b == 0) ? p0 : p1;
      for (int k = 0; k < 3; k++)
        wr_beat(b[0], k[1:0], p[23-8*k -: 8], 1'b0);
    end
  endtask

  task automatic drain(input string name);
    OUT_RDY = 1'b1;
    for (int i = 0; i < 100 && !(LEVEL == 3'd0 && sb.size() == 0); i++) begin
      @(posedge SYS_CLK);
      #1;
    end
    OUT_RDY = 1'b0;
    chk({name, "_level"}, 32'(LEVEL), 32'd0);
    chk({name, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge SYS_CLK);
    #1;
    chk("rst_out_vld", 32'(OUT_VLD), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_wr_rdy", 32'(WR_RDY), 32'd1);
    chk("rst_commit", 32'(COMMIT), 32'd0);
    chk("rst_out_last", 32'(OUT_LAST), 32'd0);
    chk("rst_out_bit", 32'(OUT_BIT), 32'd0);
    SYS_RST = 1'b1;
    @(posedge SYS_CLK);
    #1;

    // Single entry
    OUT_RDY = 1'b1;
    expect_entry(24'h112233, 24'h445566);
    wr_entry(24'h112233, 24'h445566);
    chk("single_commit", 32'(COMMIT), 32'd1);
    drain("single");

    // Full
    expect_entry(24'hA1A2A3, 24'hB1B2B3);
    wr_entry(24'hA1A2A3, 24'hB1B2B3);
    expect_entry(24'hA4A5A6, 24'hB4B5B6);
    wr_entry(24'hA4A5A6, 24'hB4B5B6);
    expect_entry(24'hA7A8A9, 24'hB7B8B9);
    wr_entry(24'hA7A8A9, 24'hB7B8B9);
    expect_entry(24'hAAABAC, 24'hBABBBC);
    wr_entry(24'hAAABAC, 24'hBABBBC);
    chk("full_wr_rdy", 32'(WR_RDY), 32'd0);
    chk("full_level", 32'(LEVEL), 32'd4);
    wr_entry(24'hDEADBE, 24'hEF0000);
    chk("full_ignored_commit", 32'(COMMIT), 32'd0);
    chk("full_ignored_level", 32'(LEVEL), 32'd4);
    OUT_RDY = 1'b1;
    repeat (2) begin
      @(posedge SYS_CLK);
      #1;
    end
    OUT_RDY = 1'b0;
    chk("pop_wr_rdy", 32'(WR_RDY), 32'd1);
    chk("pop_level", 32'(LEVEL), 32'd3);
    expect_entry(24'hC1C2C3, 24'hD1D2D3);
    wr_entry(24'hC1C2C3, 24'hD1D2D3);
    chk("refill_commit", 32'(COMMIT), 32'd1);
    chk("refill_level", 32'(LEVEL), 32'd4);
    drain("full");

    // Rotation
    PAT_LEN  = 4'd3;
    ROT_STEP = 2'd1;
    expect_entry(24'hAABBCC, 24'h0A0B0C);
    expect_entry(24'hBBCCAA, 24'h0B0C0A);
    expect_entry(24'hCCAABB, 24'h0C0A0B);
    expect_entry(24'hAABBCC, 24'h0A0B0C);
    repeat (4) wr_entry(24'hAABBCC, 24'h0A0B0C);
    drain("rot");
    PAT_LEN  = 4'd1;
    ROT_STEP = 2'd0;

    // Simultaneous commit and pop
    expect_entry(24'h313233, 24'h343536);
    wr_entry(24'h313233, 24'h343536);
    expect_entry(24'h414243, 24'h444546);
    wr_entry(24'h414243, 24'h444546);
    chk("sim_level_pre", 32'(LEVEL), 32'd2);
    expect_entry(24'h515253, 24'h545556);
    wr_beat(1'b0, 2'd0, 8'h51, 1'b0);
    wr_beat(1'b0, 2'd1, 8'h52, 1'b0);
    wr_beat(1'b0, 2'd2, 8'h53, 1'b0);
    wr_beat(1'b1, 2'd0, 8'h54, 1'b0);
    OUT_RDY = 1'b1;
    wr_beat(1'b1, 2'd1, 8'h55, 1'b0);
    wr_beat(1'b1, 2'd2, 8'h56, 1'b0);
    OUT_RDY = 1'b0;
    chk("sim_commit", 32'(COMMIT), 32'd1);
    chk("sim_level", 32'(LEVEL), 32'd2);
    drain("sim");

    // Clear beat
    expect_entry(24'h120034, 24'h56789A);
    wr_beat(1'b0, 2'd0, 8'h12, 1'b0);
    wr_beat(1'b0, 2'd1, 8'hFF, 1'b1);
    wr_beat(1'b0, 2'd2, 8'h34, 1'b0);
    wr_beat(1'b1, 2'd0, 8'h56, 1'b0);
    wr_beat(1'b1, 2'd1, 8'h78, 1'b0);
    wr_beat(1'b1, 2'd2, 8'h9A, 1'b0);
    drain("clr");

    // Reset mid-stream discards committed and partial data
    wr_entry(24'h616263, 24'h646566);
    wr_beat(1'b0, 2'd0, 8'h67, 1'b0);
    wr_beat(1'b0, 2'd1, 8'h68, 1'b0);
    SYS_RST = 1'b0;
    #2;
    chk("mid_rst_out_vld", 32'(OUT_VLD), 32'd0);
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_wr_rdy", 32'(WR_RDY), 32'd1);
    chk("mid_rst_out_data", 32'(OUT_DATA), 32'd0);
    @(posedge SYS_CLK);
    #1;
    SYS_RST = 1'b1;
    NUM_BEAT = 3'd4;
    expect_entry(24'h717273, 24'h770000);
    wr_beat(1'b0, 2'd0, 8'h71, 1'b0);
    wr_beat(1'b0, 2'd1, 8'h72, 1'b0);
    wr_beat(1'b0, 2'd2, 8'h73, 1'b0);
    chk("post_rst_no_early_commit", 32'(COMMIT), 32'd0);
    wr_beat(1'b1, 2'd0, 8'h77, 1'b0);
    chk("post_rst_commit", 32'(COMMIT), 32'd1);
    drain("post_rst");

`ifdef BPFIFO_ROW_TAP_EN
    ROW_TAP_SEL = 5'd10;
    #1;
    chk("tap_empty", 32'(ROW_TAP), 32'd0);
    NUM_BEAT = 3'd2;
    expect_entry(24'h000400, 24'h000400);
    wr_beat(1'b0, 2'd1, 8'h04, 1'b0);
    wr_beat(1'b1, 2'd1, 8'h04, 1'b0);
    chk("tap_col10", 32'(ROW_TAP), 32'd3);
    ROW_TAP_SEL = 5'd9;
    #1;
    chk("tap_col9", 32'(ROW_TAP), 32'd0);
    ROW_TAP_SEL = 5'd24;
    #1;
    chk("tap_out_of_range", 32'(ROW_TAP), 32'd0);
    drain("tap");
`endif

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
